// File: rtl/axi4_full_slave_mem.sv
// AXI4-Full memory responder: INCR/FIXED bursts up to 256 beats, one transaction per direction.
// Optional handshake stress via AXI4_SLAVE_MEM_BACKPRESSURE_EN (LFSR-driven WREADY/RVALID stalls, BVALID delay).
module axi4_full_slave_mem #(
  parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_MEM_DEPTH        = 1024
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWSIZE,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [2:0]                      S_AXI_ARSIZE,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);
  localparam int unsigned BYTES = C_S_AXI_DATA_WIDTH / 8;
  localparam int unsigned LSB   = $clog2(BYTES);
  localparam int unsigned IDX_W = $clog2(C_MEM_DEPTH);
  localparam int unsigned SUM_W = C_S_AXI_ADDR_WIDTH + 1;
  localparam int unsigned IDW   = C_S_AXI_ID_WIDTH;
  localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  // Request legality: unsupported burst/size first, then out-of-range last word.
  function automatic logic [1:0] req_resp(input logic [C_S_AXI_ADDR_WIDTH-1:0] addr,
                                          input logic [7:0] len, input logic [2:0] size,
                                          input logic [1:0] burst);
    logic [SUM_W-1:0] last_word;
    last_word = SUM_W'(addr >> LSB) + SUM_W'(len);
    if (burst != BURST_FIXED && burst != BURST_INCR) req_resp = RESP_SLVERR;
    else if (size != 3'(LSB))                        req_resp = RESP_SLVERR;
    else if (last_word >= SUM_W'(C_MEM_DEPTH))       req_resp = RESP_DECERR;
    else                                             req_resp = RESP_OKAY;
  endfunction

  logic       stall_c;
  logic [2:0] bdelay_c;

`ifdef AXI4_SLAVE_MEM_BACKPRESSURE_EN
  logic [15:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) lfsr_q <= 16'hACE1;
    else                lfsr_q <= lfsr_d;
  end
  assign stall_c  = (lfsr_q[1:0] == 2'b00);
  assign bdelay_c = lfsr_q[2:0];
`else
  assign stall_c  = 1'b0;
  assign bdelay_c = 3'd0;
`endif

  logic [DW-1:0] mem [C_MEM_DEPTH];

  // ---------------- write path ----------------
  logic [1:0]       w_state_q, w_state_d;
  logic             awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d, aw_err_q, aw_err_d;
  logic [IDW-1:0]   bid_q, bid_d;
  logic [IDX_W-1:0] widx_q, widx_d;
  logic [7:0]       wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic             wfixed_q, wfixed_d, wlast_err_q, wlast_err_d;
  logic [2:0]       bdly_q, bdly_d;
  logic             w_hs_c, w_last_c, mem_we_c;

  assign w_hs_c   = (w_state_q == W_DATA) && S_AXI_WVALID && wready_q;
  assign w_last_c = (wcnt_q == wlen_q);
  assign mem_we_c = w_hs_c && (aw_err_q == RESP_OKAY);

  always_comb begin
    w_state_d   = w_state_q;
    bresp_d     = bresp_q;
    bid_d       = bid_q;
    widx_d      = widx_q;
    wlen_d      = wlen_q;
    wcnt_d      = wcnt_q;
    wfixed_d    = wfixed_q;
    aw_err_d    = aw_err_q;
    wlast_err_d = wlast_err_q;
    bdly_d      = bdly_q;
    case (w_state_q)
      W_IDLE: if (S_AXI_AWVALID && awready_q) begin
        w_state_d   = W_DATA;
        bid_d       = S_AXI_AWID;
        widx_d      = S_AXI_AWADDR[LSB +: IDX_W];
        wlen_d      = S_AXI_AWLEN;
        wcnt_d      = 8'd0;
        wfixed_d    = (S_AXI_AWBURST == BURST_FIXED);
        aw_err_d    = req_resp(S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST);
        wlast_err_d = 1'b0;
      end
      W_DATA: if (w_hs_c) begin
        wcnt_d = wcnt_q + 8'd1;
        if (!wfixed_q) widx_d = widx_q + IDX_W'(1);
        if (S_AXI_WLAST != w_last_c) wlast_err_d = 1'b1;
        if (w_last_c) begin
          w_state_d = W_RESP;
          bdly_d    = bdelay_c;
          bresp_d   = (aw_err_q != RESP_OKAY) ? aw_err_q
                    : (wlast_err_d ? RESP_SLVERR : RESP_OKAY);
        end
      end
      W_RESP: begin
        if (bvalid_q) begin
          if (S_AXI_BREADY) w_state_d = W_IDLE;
        end else begin
          bdly_d = bdly_q - 3'd1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA) && !stall_c;
    bvalid_d  = (w_state_d == W_RESP) && (bdly_d == 3'd0);
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state_q   <= W_IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      bid_q       <= '0;
      widx_q      <= '0;
      wlen_q      <= 8'd0;
      wcnt_q      <= 8'd0;
      wfixed_q    <= 1'b0;
      aw_err_q    <= RESP_OKAY;
      wlast_err_q <= 1'b0;
      bdly_q      <= 3'd0;
    end else begin
      w_state_q   <= w_state_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      bid_q       <= bid_d;
      widx_q      <= widx_d;
      wlen_q      <= wlen_d;
      wcnt_q      <= wcnt_d;
      wfixed_q    <= wfixed_d;
      aw_err_q    <= aw_err_d;
      wlast_err_q <= wlast_err_d;
      bdly_q      <= bdly_d;
    end
  end

  // Byte-enabled write port; contents survive reset.
  always_ff @(posedge S_AXI_ACLK) begin
    if (mem_we_c) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (S_AXI_WSTRB[b]) mem[widx_q][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  logic [0:0]       r_state_q, r_state_d;
  logic             arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0]       rresp_q, rresp_d, ar_err_q, ar_err_d;
  logic [IDW-1:0]   rid_q, rid_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [IDX_W-1:0] ridx_q, ridx_d;
  logic [7:0]       rlen_q, rlen_d;
  logic [8:0]       fcnt_q, fcnt_d;
  logic             rfixed_q, rfixed_d, r_have_q, r_have_d;
  logic             r_hs_c, r_load_c;

  // rdata_q doubles as the read-ahead register: reload on every accepted beat.
  assign r_hs_c   = rvalid_q && S_AXI_RREADY;
  assign r_load_c = (r_state_q == R_DATA) && (!r_have_q || r_hs_c) && (fcnt_q <= {1'b0, rlen_q});

  always_comb begin
    r_state_d = r_state_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    ridx_d    = ridx_q;
    rlen_d    = rlen_q;
    fcnt_d    = fcnt_q;
    rfixed_d  = rfixed_q;
    ar_err_d  = ar_err_q;
    r_have_d  = r_have_q;
    case (r_state_q)
      R_IDLE: if (S_AXI_ARVALID && arready_q) begin
        r_state_d = R_DATA;
        rid_d     = S_AXI_ARID;
        ridx_d    = S_AXI_ARADDR[LSB +: IDX_W];
        rlen_d    = S_AXI_ARLEN;
        fcnt_d    = 9'd0;
        rfixed_d  = (S_AXI_ARBURST == BURST_FIXED);
        ar_err_d  = req_resp(S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST);
      end
      R_DATA: begin
        if (r_hs_c) r_have_d = 1'b0;
        if (r_load_c) begin
          rdata_d  = (ar_err_q == RESP_OKAY) ? mem[ridx_q] : '0;
          rresp_d  = ar_err_q;
          rlast_d  = (fcnt_q[7:0] == rlen_q);
          fcnt_d   = fcnt_q + 9'd1;
          if (!rfixed_q) ridx_d = ridx_q + IDX_W'(1);
          r_have_d = 1'b1;
        end
        if (r_hs_c && rlast_q) begin
          r_state_d = R_IDLE;
          rlast_d   = 1'b0;
        end
      end
    endcase
    arready_d = (r_state_d == R_IDLE);
    if (r_state_d != R_DATA)       rvalid_d = 1'b0;
    else if (rvalid_q && !r_hs_c)  rvalid_d = 1'b1;
    else                           rvalid_d = r_have_d && !stall_c;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rid_q     <= '0;
      rdata_q   <= '0;
      ridx_q    <= '0;
      rlen_q    <= 8'd0;
      fcnt_q    <= 9'd0;
      rfixed_q  <= 1'b0;
      ar_err_q  <= RESP_OKAY;
      r_have_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      ridx_q    <= ridx_d;
      rlen_q    <= rlen_d;
      fcnt_q    <= fcnt_d;
      rfixed_q  <= rfixed_d;
      ar_err_q  <= ar_err_d;
      r_have_q  <= r_have_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_BID     = bid_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RLAST   = rlast_q;
  assign S_AXI_RID     = rid_q;

endmodule

// File: tb/tb_axi4_full_slave_mem.sv
// Scoreboard bench for axi4_full_slave_mem: bursts, strobes, error responses, read stalls, mid-burst reset.
module tb_axi4_full_slave_mem;
  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:0]  S_AXI_AWID, S_AXI_BID, S_AXI_ARID, S_AXI_RID;
  logic [31:0] S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WDATA, S_AXI_RDATA;
  logic [7:0]  S_AXI_AWLEN, S_AXI_ARLEN;
  logic [2:0]  S_AXI_AWSIZE, S_AXI_ARSIZE;
  logic [1:0]  S_AXI_AWBURST, S_AXI_ARBURST, S_AXI_BRESP, S_AXI_RRESP;
  logic [3:0]  S_AXI_WSTRB;
  logic S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
  logic S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  r_exp_t      sb_r[$];
  logic [2:0]  sb_b[$];
  logic [31:0] model [DEPTH];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi4_full_slave_mem #(
    .C_S_AXI_ID_WIDTH(1), .C_S_AXI_ADDR_WIDTH(32), .C_S_AXI_DATA_WIDTH(32), .C_MEM_DEPTH(DEPTH)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
    .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WLAST(S_AXI_WLAST), .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR),
    .S_AXI_ARLEN(S_AXI_ARLEN), .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RID(S_AXI_RID),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RLAST(S_AXI_RLAST),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
  );

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic id, input logic [31:0] base, input logic [3:0] strb,
                           input logic [1:0] exp_resp);
    int t, idx;
    logic [31:0] wd;
    logic [2:0]  exp_b;
    S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = len; S_AXI_AWSIZE = 3'd2;
    S_AXI_AWBURST = burst; S_AXI_AWVALID = 1'b1;
    sb_b.push_back({id, exp_resp});
    t = 0;
    while (S_AXI_AWREADY !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    S_AXI_AWVALID = 1'b0;
    checks++;
    if (S_AXI_AWREADY !== 1'b0 || S_AXI_WREADY !== 1'b1) begin
      errors++;
      $display("FAIL aw_accept: awready=%b wready=%b required 0/1", S_AXI_AWREADY, S_AXI_WREADY);
    end
    for (int i = 0; i <= int'(len); i++) begin
      wd = base + 32'(i);
      S_AXI_WDATA = wd; S_AXI_WSTRB = strb; S_AXI_WLAST = (i == int'(len)); S_AXI_WVALID = 1'b1;
      t = 0;
      while (S_AXI_WREADY !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
      @(posedge clk); #1;
      if (exp_resp == 2'b00) begin
        idx = (burst == 2'b00) ? int'((addr >> 2) % 32'(DEPTH))
                               : int'(((addr >> 2) + 32'(i)) % 32'(DEPTH));
        for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
      end
    end
    S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
    checks++;
    if (S_AXI_BVALID !== 1'b1) begin
      errors++;
      $display("FAIL b_latency: bvalid=%b required 1 one cycle after last beat", S_AXI_BVALID);
    end
    t = 0;
    while (S_AXI_BVALID !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    S_AXI_BREADY = 1'b1;
    exp_b = sb_b.pop_front();
    checks++;
    if ({S_AXI_BID, S_AXI_BRESP} !== exp_b) begin
      errors++;
      $display("FAIL b_resp: bid=%b bresp=%b required bid=%b bresp=%b",
               S_AXI_BID, S_AXI_BRESP, exp_b[2], exp_b[1:0]);
    end
    @(posedge clk); #1;
    S_AXI_BREADY = 1'b0;
    checks++;
    if (S_AXI_BVALID !== 1'b0 || S_AXI_AWREADY !== 1'b1) begin
      errors++;
      $display("FAIL b_done: bvalid=%b awready=%b required 0/1", S_AXI_BVALID, S_AXI_AWREADY);
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic id, input logic [1:0] exp_resp, input logic [3:0] pat);
    int t, cyc, idx;
    r_exp_t e, got;
    for (int i = 0; i <= int'(len); i++) begin
      idx = (burst == 2'b00) ? int'((addr >> 2) % 32'(DEPTH))
                             : int'(((addr >> 2) + 32'(i)) % 32'(DEPTH));
      e.data = (exp_resp == 2'b00) ? model[idx] : 32'h0;
      e.resp = exp_resp;
      e.last = (i == int'(len));
      sb_r.push_back(e);
    end
    S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = len; S_AXI_ARSIZE = 3'd2;
    S_AXI_ARBURST = burst; S_AXI_ARVALID = 1'b1;
    t = 0;
    while (S_AXI_ARREADY !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    S_AXI_ARVALID = 1'b0;
    checks++;
    if (S_AXI_RVALID !== 1'b0) begin
      errors++;
      $display("FAIL r_first_early: rvalid=%b required 0 at N+1", S_AXI_RVALID);
    end
    @(posedge clk); #1;
    checks++;
    if (S_AXI_RVALID !== 1'b1) begin
      errors++;
      $display("FAIL r_first_late: rvalid=%b required 1 at N+2", S_AXI_RVALID);
    end
    cyc = 0;
    while (sb_r.size() > 0 && cyc < 2000) begin
      S_AXI_RREADY = pat[3 - (cyc % 4)];
      if (S_AXI_RVALID === 1'b1) begin
        got = {S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST};
        checks++;
        if (got !== sb_r[0] || S_AXI_RID !== id) begin
          errors++;
          $display("FAIL r_beat cyc=%0d: data=%h resp=%b last=%b id=%b required data=%h resp=%b last=%b id=%b",
                   cyc, got.data, got.resp, got.last, S_AXI_RID,
                   sb_r[0].data, sb_r[0].resp, sb_r[0].last, id);
        end
        if (S_AXI_RREADY) void'(sb_r.pop_front());
      end
      @(posedge clk); #1;
      cyc++;
    end
    S_AXI_RREADY = 1'b0;
    checks++;
    if (sb_r.size() != 0) begin
      errors++;
      $display("FAIL r_timeout: %0d beats outstanding required 0", sb_r.size());
    end
    sb_r.delete();
    if (pat == 4'b1111) begin
      checks++;
      if (cyc != int'(len) + 1) begin
        errors++;
        $display("FAIL r_back_to_back: %0d cycles required %0d", cyc, int'(len) + 1);
      end
    end
    checks++;
    if (S_AXI_RVALID !== 1'b0 || S_AXI_ARREADY !== 1'b1) begin
      errors++;
      $display("FAIL r_done: rvalid=%b arready=%b required 0/1", S_AXI_RVALID, S_AXI_ARREADY);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RLAST} !== 6'b0) begin
      errors++;
      $display("FAIL reset_handshake: aw/w/b/ar/rv/rl=%b%b%b%b%b%b required 000000", S_AXI_AWREADY,
               S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RLAST);
    end
    checks++;
    if ({S_AXI_BRESP, S_AXI_RRESP, S_AXI_BID, S_AXI_RID} !== 6'b0 || S_AXI_RDATA !== 32'h0) begin
      errors++;
      $display("FAIL reset_payload: bresp=%b rresp=%b bid=%b rid=%b rdata=%h required zeros",
               S_AXI_BRESP, S_AXI_RRESP, S_AXI_BID, S_AXI_RID, S_AXI_RDATA);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (S_AXI_AWREADY !== 1'b1 || S_AXI_ARREADY !== 1'b1 || S_AXI_WREADY !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: awready=%b arready=%b wready=%b required 1/1/0",
               S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_WREADY);
    end
  endtask

  task automatic test_burst();
    axi_write(32'h0, 8'd255, 2'b01, 1'b1, 32'h0, 4'hF, 2'b00);
    axi_read(32'h0, 8'd255, 2'b01, 1'b1, 2'b00, 4'b1111);
  endtask

  task automatic test_strobe();
    axi_write(32'h10, 8'd0, 2'b01, 1'b0, 32'h1111_1111, 4'hF, 2'b00);
    axi_write(32'h10, 8'd0, 2'b01, 1'b0, 32'hAABB_CCDD, 4'b0101, 2'b00);
    model[4] = 32'h11BB_11DD;
    axi_read(32'h10, 8'd0, 2'b01, 1'b0, 2'b00, 4'b1111);
  endtask

  task automatic test_decerr();
    axi_write((DEPTH - 2) * 4, 8'd1, 2'b01, 1'b0, 32'hCAFE_0000, 4'hF, 2'b00);
    axi_read((DEPTH - 2) * 4, 8'd3, 2'b01, 1'b1, 2'b11, 4'b1111);
    axi_write((DEPTH - 2) * 4, 8'd3, 2'b01, 1'b1, 32'hDEAD_0000, 4'hF, 2'b11);
    axi_read((DEPTH - 2) * 4, 8'd1, 2'b01, 1'b0, 2'b00, 4'b1111);
  endtask

  task automatic test_slverr_fixed();
    axi_write(32'h20, 8'd3, 2'b10, 1'b1, 32'hBAD0_0000, 4'hF, 2'b10);
    axi_read(32'h20, 8'd3, 2'b01, 1'b1, 2'b00, 4'b1111);
    axi_read(32'h20, 8'd3, 2'b10, 1'b0, 2'b10, 4'b1111);
    axi_write(32'h40, 8'd3, 2'b00, 1'b0, 32'h7777_0000, 4'hF, 2'b00);
    axi_read(32'h40, 8'd2, 2'b00, 1'b1, 2'b00, 4'b1111);
  endtask

  task automatic test_rready_toggle();
    axi_read(32'h0, 8'd7, 2'b01, 1'b0, 2'b00, 4'b1001);
  endtask

  task automatic test_reset_mid_burst();
    int t;
    S_AXI_AWID = 1'b0; S_AXI_AWADDR = 32'h0; S_AXI_AWLEN = 8'd255; S_AXI_AWSIZE = 3'd2;
    S_AXI_AWBURST = 2'b01; S_AXI_AWVALID = 1'b1;
    t = 0;
    while (S_AXI_AWREADY !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    S_AXI_AWVALID = 1'b0;
    for (int i = 0; i <= 100; i++) begin
      S_AXI_WDATA = 32'h5000_0000 + 32'(i); S_AXI_WSTRB = 4'hF; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b1;
      t = 0;
      while (S_AXI_WREADY !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
      if (i == 100) break;
      @(posedge clk); #1;
      model[i] = 32'h5000_0000 + 32'(i);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID} !== 5'b0) begin
      errors++;
      $display("FAIL midreset_async: aw/w/b/ar/rv=%b%b%b%b%b required 00000", S_AXI_AWREADY,
               S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID);
    end
    S_AXI_WVALID = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (S_AXI_AWREADY !== 1'b1 || S_AXI_BVALID !== 1'b0) begin
      errors++;
      $display("FAIL midreset_release: awready=%b bvalid=%b required 1/0", S_AXI_AWREADY, S_AXI_BVALID);
    end
    axi_read(32'h0, 8'd127, 2'b01, 1'b1, 2'b00, 4'b1111);
  endtask

  initial begin
    S_AXI_AWID = '0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWSIZE = '0; S_AXI_AWBURST = '0;
    S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0; S_AXI_ARID = '0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARSIZE = '0;
    S_AXI_ARBURST = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) model[i] = 32'h0;
    test_reset();
    test_burst();
    test_strobe();
    test_decerr();
    test_slverr_fixed();
    test_rready_toggle();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi4_full_slave_mem.md
Name: axi4_full_slave_mem

Overview:
- AXI4-Full responder backed by on-chip word memory.
- Accepts INCR/FIXED bursts of up to 256 beats on independent write and read paths.
- Serves as the memory-side counterpart for the team's burst masters, both in system simulation and as an on-chip buffer.
- Single outstanding transaction per direction. No reordering, so IDs are echoed.

Parameters:
- C_S_AXI_ID_WIDTH, 1, width of AWID/BID/ARID/RID.
- C_S_AXI_ADDR_WIDTH, 32, byte address width.
- C_S_AXI_DATA_WIDTH, 32, data width (32 or 64). BYTES = C_S_AXI_DATA_WIDTH/8.
- C_MEM_DEPTH, 1024, memory size in words (power of two).

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESETN  in  1  asynchronous active-low reset
- S_AXI_AWID  in  C_S_AXI_ID_WIDTH  write ID
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write start byte address
- S_AXI_AWLEN  in  8  beats-1
- S_AXI_AWSIZE  in  3  beat size
- S_AXI_AWBURST  in  2  burst type
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1  AW handshake
- S_AXI_WDATA  in  C_S_AXI_DATA_WIDTH  write data
- S_AXI_WSTRB  in  BYTES  byte enables
- S_AXI_WLAST  in  1  last beat
- S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1  W handshake
- S_AXI_BID  out  C_S_AXI_ID_WIDTH  echoed AWID
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1  B handshake
- S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST  in  same widths as AW  read request
- S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1  AR handshake
- S_AXI_RID  out  C_S_AXI_ID_WIDTH  echoed ARID
- S_AXI_RDATA  out  C_S_AXI_DATA_WIDTH  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RLAST  out  1  last beat
- S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1  R handshake
- LOCK/CACHE/PROT/QOS/USER are not ported; masters' outputs are left unconnected.

Behaviour:
Reset:
- All READY/VALID outputs 0; RLAST 0; BRESP/RRESP 0; BID/RID/RDATA 0.
- Both FSMs go to IDLE.
- Memory contents are not cleared.
- Reset mid-burst abandons the burst immediately; no B or R completion is issued.

Write FSM:
- W_IDLE: AWREADY=1. On AW handshake (cycle N), latch addr/len/id/burst/size; go to W_DATA. AWREADY is 0 from N+1.
- W_DATA: WREADY=1 from N+1. Each W handshake writes the bytes enabled by WSTRB to word index (addr/BYTES) mod C_MEM_DEPTH, increments beat count, and advances addr by BYTES (INCR) or holds it (FIXED).
  - On beat count == len: go to W_RESP.
  - WLAST mismatch, early or missing, sets the sticky error flag (resp=SLVERR). Transfer length is still governed by AWLEN.
- W_RESP: BVALID=1 from cycle after last beat, with BID=latched id. Hold until BREADY; then BVALID=0 and return to W_IDLE, AWREADY=1 the next cycle.
- Errors (suppress all memory writes for the burst, data still consumed):
  - AWBURST=WRAP or reserved -> SLVERR (2'b10).
  - AWSIZE != log2(BYTES) -> SLVERR.
  - start word index + len >= C_MEM_DEPTH -> DECERR (2'b11).
  - Otherwise OKAY (2'b00).

Read FSM:
- R_IDLE: ARREADY=1. On AR handshake (cycle N), latch request; go to R_DATA.
- R_DATA:
  - Synchronous memory read; first RVALID at N+2.
  - Read-ahead prefetch register sustains one beat per cycle while RREADY=1.
  - RDATA/RRESP/RLAST stable while RVALID=1 and RREADY=0.
  - RLAST=1 only on beat len.
  - After last handshake, RVALID=0 and return to R_IDLE; ARREADY=1 the next cycle.
- Error bursts (same rules as write, ARSIZE/ARBURST/range) return len+1 beats with RDATA=0 and RRESP=SLVERR/DECERR.

Concurrency and arithmetic:
- Read and write paths are fully independent.
- Same-word read and write in the same cycle: read returns the old data.
- Address arithmetic is C_S_AXI_ADDR_WIDTH bits. The 4 KB boundary is not checked.

Optional Feature:
- Macro: AXI4_SLAVE_MEM_BACKPRESSURE_EN.
- Defined: a 16-bit LFSR (seed 16'hACE1, reset value) gates WREADY in W_DATA and RVALID in R_DATA (stall when lfsr[1:0]==2'b00) and delays BVALID by lfsr[2:0] cycles. Data and order are unchanged. Purpose: stress master handshakes.
- Undefined: no stalls; timing exactly as above.

Test Plan:
- AW addr 0x0 len 255 INCR, W data = beat index, WLAST on beat 255 -> 256 writes, BVALID the cycle after beat 255, BRESP=00, BID=AWID.
- AR addr 0x0 len 255 after the above -> RVALID at N+2, RDATA 0..255 back-to-back with RREADY=1, RLAST only on 255, RRESP=00.
- Write addr 0x10 len 0, WSTRB=4'b0101, data 0xAABBCCDD over 0x11111111 -> readback 0x11BB11DD.
- AR addr (C_MEM_DEPTH-2)*BYTES len 3 -> 4 beats, RRESP=11, RDATA=0. Same AW -> BRESP=11, memory unchanged.
- Read len 7 with RREADY toggling 1,0,0,1… -> each beat held stable while stalled, 8 beats in order, single RLAST.
- Assert ARESETN=0 at write beat 100 of 256 -> all VALID/READY 0 asynchronously; after release AWREADY=1; beats 0..99 retained in memory.
